// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline-control types: forwarding-select encodings and stage-shadow control structs.
package rv32_pipe_pkg;

  localparam logic [1:0] FwdRegfile = 2'b00;
  localparam logic [1:0] FwdExMem   = 2'b01;
  localparam logic [1:0] FwdMemWb   = 2'b10;

  // Register indices are held beside these structs because their width is a module parameter.
  typedef struct packed {
    logic v;
    logic rw;
    logic mr;
    logic use1;
    logic use2;
  } ex_ctrl_t;

  typedef struct packed {
    logic v;
    logic rw;
  } wb_ctrl_t;

endpackage

// File: rtl/rv32_muldiv_occupancy.sv
// Occupancy counter for multi-cycle MUL/DIV ops; busy while the op still owes cycles in EX.
module rv32_muldiv_occupancy #(
  parameter int unsigned MulDivLat = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic freeze_i,
  input  logic load_i,
  output logic md_busy_o
);

  localparam int unsigned CntW = (MulDivLat > 1) ? $clog2(MulDivLat) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end else if (load_i) begin
        cnt_d = CntW'(MulDivLat - 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy_o = (cnt_q != '0);

endmodule

// File: rtl/rv32_hazard_ctrl.sv
// 5-stage pipeline hazard control: shadow EX/MEM/WB destinations drive forwarding, stalls and flushes.
module rv32_hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned RegAddrW    = 5,
  parameter int unsigned MulDivLat   = 4,
  parameter bit          FwdEnable   = 1'b1,
  parameter bit          X0Hardwired = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                busywait_i,
  input  logic                id_valid_i,
  input  logic [RegAddrW-1:0] id_rs1_i,
  input  logic [RegAddrW-1:0] id_rs2_i,
  input  logic                id_use_rs1_i,
  input  logic                id_use_rs2_i,
  input  logic [RegAddrW-1:0] id_rd_i,
  input  logic                id_regwrite_i,
  input  logic                id_memread_i,
  input  logic                id_muldiv_i,
  input  logic                branch_taken_i,
  output logic                stall_pc_o,
  output logic                stall_if_id_o,
  output logic                stall_id_ex_o,
  output logic                flush_if_id_o,
  output logic                flush_id_ex_o,
  output logic                bubble_ex_mem_o,
  output logic [1:0]          fwd_a_o,
  output logic [1:0]          fwd_b_o,
  output logic                md_busy_o
);

  ex_ctrl_t            ex_q, ex_d;
  logic [RegAddrW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  wb_ctrl_t            mem_q, mem_d, wb_q, wb_d;
  logic [RegAddrW-1:0] mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;

  logic       md_busy, md_load, load_use;
  logic       ex_hit, mem_hit, wb_hit;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic hit(logic v, logic rw, logic [RegAddrW-1:0] rd,
                               logic [RegAddrW-1:0] src, logic use_src);
    return v & rw & use_src & (rd == src) & ~(X0Hardwired & (rd == '0));
  endfunction

  // Forwarding selects for the operands of the instruction sitting in EX.
  always_comb begin
    fwd_a = FwdRegfile;
    fwd_b = FwdRegfile;
    if (FwdEnable) begin
      if (hit(mem_q.v, mem_q.rw, mem_rd_q, ex_rs1_q, ex_q.v & ex_q.use1)) begin
        fwd_a = FwdExMem;
      end else if (hit(wb_q.v, wb_q.rw, wb_rd_q, ex_rs1_q, ex_q.v & ex_q.use1)) begin
        fwd_a = FwdMemWb;
      end
      if (hit(mem_q.v, mem_q.rw, mem_rd_q, ex_rs2_q, ex_q.v & ex_q.use2)) begin
        fwd_b = FwdExMem;
      end else if (hit(wb_q.v, wb_q.rw, wb_rd_q, ex_rs2_q, ex_q.v & ex_q.use2)) begin
        fwd_b = FwdMemWb;
      end
    end
  end

  assign ex_hit  = hit(ex_q.v, ex_q.rw, ex_rd_q, id_rs1_i, id_valid_i & id_use_rs1_i)
                 | hit(ex_q.v, ex_q.rw, ex_rd_q, id_rs2_i, id_valid_i & id_use_rs2_i);
  assign mem_hit = hit(mem_q.v, mem_q.rw, mem_rd_q, id_rs1_i, id_valid_i & id_use_rs1_i)
                 | hit(mem_q.v, mem_q.rw, mem_rd_q, id_rs2_i, id_valid_i & id_use_rs2_i);
  assign wb_hit  = hit(wb_q.v, wb_q.rw, wb_rd_q, id_rs1_i, id_valid_i & id_use_rs1_i)
                 | hit(wb_q.v, wb_q.rw, wb_rd_q, id_rs2_i, id_valid_i & id_use_rs2_i);

  // Without forwarding, any in-flight producer blocks the consumer until it retires.
  assign load_use = FwdEnable ? (ex_hit & ex_q.mr) : (ex_hit | mem_hit | wb_hit);

  always_comb begin
    stall_pc_o      = 1'b0;
    stall_if_id_o   = 1'b0;
    stall_id_ex_o   = 1'b0;
    flush_if_id_o   = 1'b0;
    flush_id_ex_o   = 1'b0;
    bubble_ex_mem_o = 1'b0;
    fwd_a_o         = FwdRegfile;
    fwd_b_o         = FwdRegfile;
    md_busy_o       = 1'b0;
    if (rst_ni) begin
      fwd_a_o   = fwd_a;
      fwd_b_o   = fwd_b;
      md_busy_o = md_busy;
      if (!busywait_i) begin
        if (md_busy) begin
          stall_pc_o      = 1'b1;
          stall_if_id_o   = 1'b1;
          stall_id_ex_o   = 1'b1;
          bubble_ex_mem_o = 1'b1;
        end else if (branch_taken_i) begin
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (load_use) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ex_d     = ex_q;
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    ex_rd_d  = ex_rd_q;
    mem_d    = mem_q;
    mem_rd_d = mem_rd_q;
    wb_d     = wb_q;
    wb_rd_d  = wb_rd_q;
    if (!busywait_i) begin
      wb_d    = mem_q;
      wb_rd_d = mem_rd_q;
      if (md_busy) begin
        mem_d    = '0;
        mem_rd_d = '0;
      end else begin
        mem_d    = '{v: ex_q.v, rw: ex_q.rw};
        mem_rd_d = ex_rd_q;
        if (flush_id_ex_o) begin
          ex_d     = '0;
          ex_rs1_d = '0;
          ex_rs2_d = '0;
          ex_rd_d  = '0;
        end else begin
          ex_d     = '{v: id_valid_i, rw: id_regwrite_i, mr: id_memread_i,
                       use1: id_use_rs1_i, use2: id_use_rs2_i};
          ex_rs1_d = id_rs1_i;
          ex_rs2_d = id_rs2_i;
          ex_rd_d  = id_rd_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      ex_rd_q  <= '0;
      mem_q    <= '0;
      mem_rd_q <= '0;
      wb_q     <= '0;
      wb_rd_q  <= '0;
    end else begin
      ex_q     <= ex_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      ex_rd_q  <= ex_rd_d;
      mem_q    <= mem_d;
      mem_rd_q <= mem_rd_d;
      wb_q     <= wb_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  // Counter arms on the same edge the M-extension op is written into EX.
  assign md_load = ~busywait_i & ~md_busy & ~flush_id_ex_o & id_valid_i & id_muldiv_i;

  rv32_muldiv_occupancy #(
    .MulDivLat (MulDivLat)
  ) u_muldiv_occupancy (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .freeze_i  (busywait_i),
    .load_i    (md_load),
    .md_busy_o (md_busy)
  );

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed and randomized checks of rv32_hazard_ctrl against an instruction-level pipeline model.
module tb_rv32_hazard_ctrl;

  localparam int Lat = 4;

  typedef struct packed {
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit rw;
    bit mr;
    bit md;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst_n, busywait, branch_taken;
  ins_t       id;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, bubble_ex_mem;
  logic       md_busy;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  // Reference pipeline: whole instructions per stage plus cycles the EX op has spent there.
  ins_t m_ex, m_mem, m_wb;
  int   md_age;
  logic e_spc, e_sif, e_sidex, e_fif, e_fidex, e_bub, e_busy;
  logic [1:0] e_fa, e_fb;

  assign id_rs1 = id.rs1[4:0];
  assign id_rs2 = id.rs2[4:0];
  assign id_rd  = id.rd[4:0];

  always #5 clk = ~clk;

  rv32_hazard_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .busywait_i      (busywait),
    .id_valid_i      (id.v),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_use_rs1_i    (id.u1),
    .id_use_rs2_i    (id.u2),
    .id_rd_i         (id_rd),
    .id_regwrite_i   (id.rw),
    .id_memread_i    (id.mr),
    .id_muldiv_i     (id.md),
    .branch_taken_i  (branch_taken),
    .stall_pc_o      (stall_pc),
    .stall_if_id_o   (stall_if_id),
    .stall_id_ex_o   (stall_id_ex),
    .flush_if_id_o   (flush_if_id),
    .flush_id_ex_o   (flush_id_ex),
    .bubble_ex_mem_o (bubble_ex_mem),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b),
    .md_busy_o       (md_busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit dep(ins_t p, int src, bit u);
    return p.v && p.rw && u && (p.rd == src) && (p.rd != 0);
  endfunction

  function automatic logic [1:0] fwd_sel(int src, bit u);
    if (!m_ex.v) return 2'd0;
    if (dep(m_mem, src, u)) return 2'd1;
    if (dep(m_wb, src, u)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_ex = '0;
    m_mem = '0;
    m_wb = '0;
    md_age = 0;
  endtask

  task automatic model_eval();
    bit lu;
    e_busy = m_ex.v && m_ex.md && (md_age < Lat - 1);
    lu = id.v && m_ex.mr && (dep(m_ex, id.rs1, id.u1) || dep(m_ex, id.rs2, id.u2));
    {e_spc, e_sif, e_sidex, e_fif, e_fidex, e_bub} = '0;
    e_fa = 2'd0;
    e_fb = 2'd0;
    if (rst_n) begin
      e_fa = fwd_sel(m_ex.rs1, m_ex.u1);
      e_fb = fwd_sel(m_ex.rs2, m_ex.u2);
      if (!busywait) begin
        if (e_busy) {e_spc, e_sif, e_sidex, e_bub} = '1;
        else if (branch_taken) {e_fif, e_fidex} = '1;
        else if (lu) {e_spc, e_sif, e_fidex} = '1;
      end
    end else begin
      e_busy = 1'b0;
    end
  endtask

  task automatic model_advance();
    if (!rst_n) begin
      model_reset();
    end else if (!busywait) begin
      m_wb = m_mem;
      if (e_busy) begin
        md_age++;
        m_mem = '0;
      end else begin
        m_mem = m_ex;
        m_ex = e_fidex ? '0 : id;
        md_age = 0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("stall_pc", stall_pc, e_spc);
    chk("stall_if_id", stall_if_id, e_sif);
    chk("stall_id_ex", stall_id_ex, e_sidex);
    chk("flush_if_id", flush_if_id, e_fif);
    chk("flush_id_ex", flush_id_ex, e_fidex);
    chk("bubble_ex_mem", bubble_ex_mem, e_bub);
    chk("fwd_a", fwd_a, e_fa);
    chk("fwd_b", fwd_b, e_fb);
    chk("md_busy", md_busy, e_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  // v, rs1, use1, rs2, use2, rd, regwrite, memread, muldiv
  function automatic ins_t mk(int rs1, bit u1, int rs2, bit u2, int rd, bit rw, bit mr, bit md);
    ins_t i;
    i.v = 1'b1;
    i.rs1 = rs1;
    i.u1 = u1;
    i.rs2 = rs2;
    i.u2 = u2;
    i.rd = rd;
    i.rw = rw;
    i.mr = mr;
    i.md = md;
    return i;
  endfunction

  initial begin
    int nb, nbub;
    rst_n = 1'b0;
    busywait = 1'b0;
    branch_taken = 1'b0;
    id = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall_pc", stall_pc, 0);
    chk("reset_md_busy", md_busy, 0);
    chk("reset_fwd_a", fwd_a, 0);
    chk("reset_flush_id_ex", flush_id_ex, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // add x1; add x2,x1,x3
    id = mk(3, 1, 4, 1, 1, 1, 0, 0); sample(); tick();
    id = mk(1, 1, 3, 1, 2, 1, 0, 0); sample(); chk("t1_no_stall", stall_pc, 0); tick();
    id = '0; sample();
    chk("t1_fwd_a", fwd_a, 1);
    chk("t1_fwd_b", fwd_b, 0);
    tick();

    // lw x5; add x6,x5,x5
    id = mk(1, 1, 0, 0, 5, 1, 1, 0); sample(); tick();
    id = mk(5, 1, 5, 1, 6, 1, 0, 0); sample();
    chk("t2_stall_pc", stall_pc, 1);
    chk("t2_stall_if_id", stall_if_id, 1);
    chk("t2_flush_id_ex", flush_id_ex, 1);
    tick();
    sample(); chk("t2_stall_once", stall_pc, 0); tick();
    id = '0; sample();
    chk("t2_fwd_a", fwd_a, 2);
    chk("t2_fwd_b", fwd_b, 2);
    tick();

    // mul x7, then dependent add
    id = mk(1, 1, 2, 1, 7, 1, 0, 1); sample(); tick();
    id = mk(7, 1, 0, 1, 8, 1, 0, 0);
    nb = 0;
    nbub = 0;
    repeat (3) begin
      sample();
      nb += int'(md_busy);
      nbub += int'(bubble_ex_mem);
      tick();
    end
    chk("t3_busy_cycles", nb, 3);
    chk("t3_bubble_cycles", nbub, 3);
    sample(); chk("t3_busy_done", md_busy, 0); tick();
    id = '0; sample(); chk("t3_fwd_a", fwd_a, 1); tick();

    // branch taken alongside a load-use match
    id = mk(1, 1, 2, 1, 9, 1, 1, 0); sample(); tick();
    id = mk(9, 1, 9, 1, 10, 1, 0, 0);
    branch_taken = 1'b1;
    sample();
    chk("t4_flush_if_id", flush_if_id, 1);
    chk("t4_flush_id_ex", flush_id_ex, 1);
    chk("t4_stall_pc", stall_pc, 0);
    tick();
    branch_taken = 1'b0;
    id = '0; sample(); tick();

    // busywait while the mul counter sits at 2
    id = mk(1, 1, 2, 1, 7, 1, 0, 1); sample(); tick();
    id = mk(7, 1, 0, 0, 8, 1, 0, 0); sample(); tick();
    busywait = 1'b1;
    repeat (5) begin
      sample();
      chk("t5_bw_stall_pc", stall_pc, 0);
      tick();
    end
    busywait = 1'b0;
    nb = 0;
    repeat (4) begin
      sample();
      nb += int'(md_busy);
      tick();
    end
    chk("t5_busy_after_release", nb, 2);

    // x0 never forwards
    id = mk(1, 1, 2, 1, 0, 1, 0, 0); sample(); tick();
    id = mk(0, 1, 0, 1, 1, 1, 0, 0); sample(); tick();
    id = '0; sample();
    chk("t6_fwd_a", fwd_a, 0);
    chk("t6_fwd_b", fwd_b, 0);
    tick();

    // reset asserted in the middle of a mul
    id = mk(1, 1, 2, 1, 7, 1, 0, 1); sample(); tick();
    id = '0;
    branch_taken = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_md_busy", md_busy, 0);
    chk("t6_rst_stall_pc", stall_pc, 0);
    chk("t6_rst_bubble", bubble_ex_mem, 0);
    chk("t6_rst_flush_if_id", flush_if_id, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    branch_taken = 1'b0;

    for (int n = 0; n < 600; n++) begin
      id.v = ($urandom_range(0, 7) != 0);
      id.rs1 = $urandom_range(0, 3);
      id.rs2 = $urandom_range(0, 3);
      id.u1 = $urandom_range(0, 1);
      id.u2 = $urandom_range(0, 1);
      id.rd = $urandom_range(0, 3);
      id.rw = ($urandom_range(0, 3) != 0);
      id.mr = ($urandom_range(0, 3) == 0);
      id.md = ($urandom_range(0, 6) == 0);
      busywait = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
